// File: rtl/bin_cnt_param.sv
// bin_cnt_param: modulo-N up/down counter with clear, parallel load and
// count enable. Wraps or saturates at the range ends (SATURATE). Provides a
// combinational terminal count for cascading and registered wrap/sat flags.
module bin_cnt_param #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = 64'd15,
  parameter bit              SATURATE = 1'b0,
  parameter longint unsigned RST_VAL  = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_RST  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;
  logic             w_next_sat;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == C_MAX);
  assign w_at_zero = (r_count == C_ZERO);

  // Out-of-range load values clamp to the top of the counting range.
  always_comb begin
    if (load_val > C_MAX) begin
      w_load_clamped = C_MAX;
    end else begin
      w_load_clamped = load_val;
    end
  end

  // Next-state selection with priority clr > load > en.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    w_next_sat   = r_sat;
    if (clr) begin
      w_next_count = C_RST;
      w_next_wrap  = 1'b0;
      w_next_sat   = 1'b0;
    end else if (load) begin
      w_next_count = w_load_clamped;
      w_next_wrap  = 1'b0;
      if (SATURATE) begin
        w_next_sat = up_dn ? (w_load_clamped == C_MAX) : (w_load_clamped == C_ZERO);
      end else begin
        w_next_sat = 1'b0;
      end
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          // Boundary event: wrap to zero or hold at the top.
          w_next_wrap = 1'b1;
          if (SATURATE) begin
            w_next_count = r_count;
            w_next_sat   = 1'b1;
          end else begin
            w_next_count = C_ZERO;
            w_next_sat   = 1'b0;
          end
        end else begin
          w_next_count = r_count + C_ONE;
          w_next_sat   = 1'b0;
        end
      end else begin
        if (w_at_zero) begin
          // Boundary event: wrap to the top or hold at zero.
          w_next_wrap = 1'b1;
          if (SATURATE) begin
            w_next_count = r_count;
            w_next_sat   = 1'b1;
          end else begin
            w_next_count = C_MAX;
            w_next_sat   = 1'b0;
          end
        end else begin
          w_next_count = r_count - C_ONE;
          w_next_sat   = 1'b0;
        end
      end
    end else begin
      w_next_count = r_count;
      w_next_wrap  = 1'b0;
      w_next_sat   = r_sat;
    end
  end

  // State registers; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= C_RST;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
      r_sat   <= w_next_sat;
    end
  end

  // Terminal count is combinational so a higher stage can use it as its enable.
  always_comb begin
    if (up_dn) begin
      tc = en & w_at_max;
    end else begin
      tc = en & w_at_zero;
    end
  end

  assign counter = r_count;
  assign wrap    = r_wrap;
  assign sat     = r_sat;

endmodule

// File: tb/tb_bin_cnt_param.sv
// Directed self-checking bench for bin_cnt_param: wrap counter, decade
// counter with cascade, saturating counter, priority, async reset, hold.
module tb_bin_cnt_param;

  logic clk;
  logic rst;

  // Instance A: WIDTH=4, MAX_VAL=15, wrap mode
  logic       a_en, a_up, a_clr, a_load;
  logic [3:0] a_lv, a_cnt;
  logic       a_tc, a_wrap, a_sat;
  // Instance D: MAX_VAL=9, wrap mode
  logic       d_en, d_up, d_clr, d_load;
  logic [3:0] d_lv, d_cnt;
  logic       d_tc, d_wrap, d_sat;
  // Instance S: MAX_VAL=9, saturate mode
  logic       s_en, s_up, s_clr, s_load;
  logic [3:0] s_lv, s_cnt;
  logic       s_tc, s_wrap, s_sat;
  // Cascaded decades: lo.tc drives hi.en
  logic       c_en, c_up, c_zero;
  logic [3:0] c_lv, l_cnt, h_cnt;
  logic       l_tc, l_wrap, l_sat, h_tc, h_wrap, h_sat;

  int n_vec;
  int n_miss;

  bin_cnt_param #(.WIDTH(4), .MAX_VAL(64'd15), .SATURATE(1'b0), .RST_VAL(64'd0)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .clr(a_clr), .load(a_load),
    .load_val(a_lv), .counter(a_cnt), .tc(a_tc), .wrap(a_wrap), .sat(a_sat));

  bin_cnt_param #(.WIDTH(4), .MAX_VAL(64'd9), .SATURATE(1'b0), .RST_VAL(64'd0)) u_d (
    .clk(clk), .rst(rst), .en(d_en), .up_dn(d_up), .clr(d_clr), .load(d_load),
    .load_val(d_lv), .counter(d_cnt), .tc(d_tc), .wrap(d_wrap), .sat(d_sat));

  bin_cnt_param #(.WIDTH(4), .MAX_VAL(64'd9), .SATURATE(1'b1), .RST_VAL(64'd0)) u_s (
    .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up), .clr(s_clr), .load(s_load),
    .load_val(s_lv), .counter(s_cnt), .tc(s_tc), .wrap(s_wrap), .sat(s_sat));

  bin_cnt_param #(.WIDTH(4), .MAX_VAL(64'd9), .SATURATE(1'b0), .RST_VAL(64'd0)) u_lo (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(c_up), .clr(c_zero), .load(c_zero),
    .load_val(c_lv), .counter(l_cnt), .tc(l_tc), .wrap(l_wrap), .sat(l_sat));

  bin_cnt_param #(.WIDTH(4), .MAX_VAL(64'd9), .SATURATE(1'b0), .RST_VAL(64'd0)) u_hi (
    .clk(clk), .rst(rst), .en(l_tc), .up_dn(c_up), .clr(c_zero), .load(c_zero),
    .load_val(c_lv), .counter(h_cnt), .tc(h_tc), .wrap(h_wrap), .sat(h_sat));

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b0;
    a_en = 1'b0; a_up = 1'b1; a_clr = 1'b0; a_load = 1'b0; a_lv = 4'd0;
    d_en = 1'b0; d_up = 1'b1; d_clr = 1'b0; d_load = 1'b0; d_lv = 4'd0;
    s_en = 1'b0; s_up = 1'b1; s_clr = 1'b0; s_load = 1'b0; s_lv = 4'd0;
    c_en = 1'b0; c_up = 1'b1; c_zero = 1'b0; c_lv = 4'd0;

    #199;
    chk_eq("rst_cnt", 32'(a_cnt), 32'd0);
    chk_eq("rst_wrap", 32'(a_wrap), 32'd0);
    chk_eq("rst_sat", 32'(s_sat), 32'd0);
    #1;

    // Test 1: 20 up-counts mod 16
    rst = 1'b1; a_en = 1'b1; a_up = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk_eq("t1_cnt", 32'(a_cnt), 32'(i % 16));
      chk_eq("t1_tc", 32'(a_tc), 32'((i % 16) == 15));
      chk_eq("t1_wrap", 32'(a_wrap), 32'(i == 16));
      step();
    end
    a_en = 1'b0;

    // Test 2a: decade up, then down across zero
    d_en = 1'b1; d_up = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk_eq("t2_cnt", 32'(d_cnt), 32'(k));
      chk_eq("t2_tc", 32'(d_tc), 32'(k == 9));
      step();
    end
    chk_eq("t2_rollup", 32'(d_cnt), 32'd0);
    chk_eq("t2_wrapup", 32'(d_wrap), 32'd1);
    d_up = 1'b0;
    #1;
    chk_eq("t2_tcdn", 32'(d_tc), 32'd1);
    step();
    chk_eq("t2_rolldn", 32'(d_cnt), 32'd9);
    chk_eq("t2_wrapdn", 32'(d_wrap), 32'd1);
    step();
    chk_eq("t2_dn8", 32'(d_cnt), 32'd8);
    chk_eq("t2_wrap0", 32'(d_wrap), 32'd0);

    // Test 4: priority clr > load > en, load clamp
    d_clr = 1'b1; d_load = 1'b1; d_lv = 4'd5; d_en = 1'b1;
    step();
    chk_eq("t4_clr", 32'(d_cnt), 32'd0);
    d_clr = 1'b0; d_en = 1'b0; d_lv = 4'd12;
    step();
    chk_eq("t4_clamp", 32'(d_cnt), 32'd9);
    d_en = 1'b1; d_lv = 4'd3;
    step();
    chk_eq("t4_ld_en", 32'(d_cnt), 32'd3);
    chk_eq("t4_wrap", 32'(d_wrap), 32'd0);
    d_load = 1'b0; d_en = 1'b0;

    // Test 2b: cascaded decades 00..99 -> 00
    c_en = 1'b1;
    #1;
    for (int i = 0; i <= 100; i++) begin
      chk_eq("t2c_val", 32'(int'(h_cnt) * 10 + int'(l_cnt)), 32'(i % 100));
      chk_eq("t2c_hwrap", 32'(h_wrap), 32'(i == 100));
      if (i < 100) step();
    end
    c_en = 1'b0;

    // Test 3: saturating counter
    s_en = 1'b1; s_up = 1'b1;
    #1;
    for (int k = 0; k <= 12; k++) begin
      chk_eq("t3_cnt", 32'(s_cnt), 32'((k < 9) ? k : 9));
      chk_eq("t3_sat", 32'(s_sat), 32'(k >= 10));
      chk_eq("t3_wrap", 32'(s_wrap), 32'(k >= 10));
      if (k == 9) chk_eq("t3_tc", 32'(s_tc), 32'd1);
      if (k < 12) step();
    end
    s_up = 1'b0;
    #1;
    chk_eq("t3_tcdn", 32'(s_tc), 32'd0);
    step();
    chk_eq("t3_away", 32'(s_cnt), 32'd8);
    chk_eq("t3_satclr", 32'(s_sat), 32'd0);
    chk_eq("t3_wrapclr", 32'(s_wrap), 32'd0);
    s_en = 1'b0; s_load = 1'b1; s_lv = 4'd0;
    step();
    chk_eq("t3_ldcnt", 32'(s_cnt), 32'd0);
    chk_eq("t3_ldsat", 32'(s_sat), 32'd1);
    s_load = 1'b0;
    step();
    chk_eq("t3_sathold", 32'(s_sat), 32'd1);

    // Test 6: en=0 holds at 4; tc low even at the ends
    for (int i = 0; i < 5; i++) begin
      chk_eq("t6_cnt", 32'(a_cnt), 32'd4);
      chk_eq("t6_tc", 32'(a_tc), 32'd0);
      chk_eq("t6_wrap", 32'(a_wrap), 32'd0);
      step();
    end
    a_up = 1'b1; a_load = 1'b1; a_lv = 4'd15;
    step();
    chk_eq("t6_max", 32'(a_cnt), 32'd15);
    chk_eq("t6_tcmax", 32'(a_tc), 32'd0);
    a_up = 1'b0; a_lv = 4'd0;
    step();
    chk_eq("t6_zero", 32'(a_cnt), 32'd0);
    chk_eq("t6_tczero", 32'(a_tc), 32'd0);

    // Test 5: async reset mid-count
    a_lv = 4'd7; a_up = 1'b1;
    step();
    chk_eq("t5_pre", 32'(a_cnt), 32'd7);
    a_load = 1'b0; a_en = 1'b1; s_en = 1'b1; s_up = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_eq("t5_cnt", 32'(a_cnt), 32'd0);
    chk_eq("t5_wrap", 32'(a_wrap), 32'd0);
    chk_eq("t5_sat", 32'(s_sat), 32'd0);
    step();
    chk_eq("t5_hold1", 32'(a_cnt), 32'd0);
    step();
    chk_eq("t5_hold2", 32'(a_cnt), 32'd0);
    #2;
    rst = 1'b1;
    step();
    chk_eq("t5_resume", 32'(a_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
